// File: rtl/ce_window_gen_pkg.sv
// ce_pkg: shared types and index/width helpers for the CE window generator
package ce_pkg;

   typedef enum logic {FILL, RUN} state_t;

   function automatic int clog2(input int v);
      int w;
      for (w = 1; (1 << w) < v; w++) ;
      return w;
   endfunction

   function automatic int win_idx(input int i, input int r, input int c, input int k, input int n);
      return ((i * k + r) * k + c) * n;
   endfunction

endpackage

// File: rtl/ce_window_gen_line_buf.sv
// ce_line_buf: one image-row delay line, read-before-write at the same column each accept
module ce_line_buf import ce_pkg::*; #(
   parameter int DEPTH = 28,
   parameter int DW    = 28
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [clog2(DEPTH)-1:0] addr,
   input  logic [DW-1:0]           din,
   output logic [DW-1:0]           dout
);

   logic [DW-1:0] mem [DEPTH];

   assign dout = mem[addr];

   // store this row's pixel; the previous row's pixel at this column is read above
   always_ff @(posedge clk)
      if (we) mem[addr] <= din;

endmodule

// File: rtl/ce_window_gen.sv
// ce_window_gen: raster pixel stream to KERNEL x KERNEL sliding windows for the CE block
// Optional sticky sof_err output when CE_WIN_SOF_CHECK_EN is defined.
module ce_window_gen import ce_pkg::*; #(
   parameter int CL_IN  = 14,
   parameter int KERNEL = 3,
   parameter int N      = 2,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CL_IN*N-1:0]               pix_in,
   input  logic                             pix_valid,
   input  logic                             sof,
   output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
   output logic                             en_out,
   output logic                             frame_done
`ifdef CE_WIN_SOF_CHECK_EN
   ,output logic                            sof_err
`endif
);

   localparam int CW = clog2(IMG_W);
   localparam int RW = clog2(IMG_H);
   localparam int PW = CL_IN * N;
   localparam int WW = PW * KERNEL * KERNEL;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FILL = RW'(KERNEL > 1 ? KERNEL - 2 : 0);
   localparam state_t SOF_STATE = KERNEL == 1 ? RUN : FILL;

   logic [CW-1:0] col, c_eff;
   logic [RW-1:0] row, r_eff;
   state_t        state, s_eff, s_next;
   logic          row_end, last, win_valid;
   logic [PW-1:0] tap [KERNEL];
   logic [WW-1:0] win, win_next;

   // a qualified sof relabels the beat as (0,0) and restarts the fill
   assign c_eff     = sof ? '0 : col;
   assign r_eff     = sof ? '0 : row;
   assign s_eff     = sof ? SOF_STATE : state;
   assign row_end   = c_eff == COL_LAST;
   assign last      = row_end && r_eff == ROW_LAST;
   assign win_valid = pix_valid && (KERNEL == 1 || s_eff == RUN) && c_eff >= COL_WIN;
   assign s_next    = last ? SOF_STATE :
                      (KERNEL > 1 && row_end && r_eff == ROW_FILL) ? RUN : s_eff;

   // newest row is the live pixel; each line buffer supplies one row older
   assign tap[KERNEL-1] = pix_in;
   for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
      ce_line_buf #(.DEPTH(IMG_W), .DW(PW)) u_lb (
         .clk  (clk),
         .we   (pix_valid),
         .addr (c_eff),
         .din  (tap[KERNEL-1-j]),
         .dout (tap[KERNEL-2-j])
      );
   end

   // shift window left one column; right column comes from the taps
   for (genvar i = 0; i < CL_IN; i++) begin : g_ch
      for (genvar r = 0; r < KERNEL; r++) begin : g_row
         for (genvar c = 0; c < KERNEL; c++) begin : g_col
            if (c == KERNEL - 1) begin : g_new
               assign win_next[win_idx(i, r, c, KERNEL, N) +: N] = tap[r][i*N +: N];
            end else begin : g_shift
               assign win_next[win_idx(i, r, c, KERNEL, N) +: N] = win[win_idx(i, r, c + 1, KERNEL, N) +: N];
            end
         end
      end
   end

   // position counters, FSM and window register advance only on accepted pixels
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col   <= '0;
         row   <= '0;
         state <= FILL;
         win   <= '0;
      end else if (pix_valid) begin
         col   <= row_end ? '0 : c_eff + 1'b1;
         row   <= last ? '0 : row_end ? r_eff + 1'b1 : r_eff;
         state <= s_next;
         win   <= win_next;
      end

   // registered outputs: strobes each cycle, window only when a full one is available
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         data2conv  <= '0;
         en_out     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         en_out     <= win_valid;
         frame_done <= pix_valid && last;
         if (win_valid) data2conv <= win_next;
      end

`ifdef CE_WIN_SOF_CHECK_EN
   // sticky flag: sof away from (0,0), or (0,0) accepted without sof
   always_ff @(posedge clk or posedge rst)
      if (rst) sof_err <= 1'b0;
      else if (pix_valid && (sof ? (col != '0 || row != '0) : (col == '0 && row == '0))) sof_err <= 1'b1;
`endif

endmodule

// File: tb/tb_ce_window_gen.sv
// tb_ce_window_gen: directed checks of window sequencing, stalls, framing, packing and reset
module tb_ce_window_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        sof;
   logic [71:0] data2conv;
   logic        en_out;
   logic        frame_done;
`ifdef CE_WIN_SOF_CHECK_EN
   logic        sof_err;
`endif

   int tests = 0;
   int fails = 0;
   int mc, mr, nwin;
   logic [71:0] last_win;

   always #5 clk = ~clk;

   ce_window_gen #(.CL_IN(2), .KERNEL(3), .N(4), .IMG_W(5), .IMG_H(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .sof        (sof),
      .data2conv  (data2conv),
      .en_out     (en_out),
      .frame_done (frame_done)
`ifdef CE_WIN_SOF_CHECK_EN
      ,.sof_err   (sof_err)
`endif
   );

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // expected 3x3 window ending at (r,c) of a 5-wide frame whose pixels are raster index + off
   function automatic logic [35:0] wexp(input int r, input int c, input int off);
      logic [35:0] w;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            w[(rr*3+cc)*4 +: 4] = 4'(((r - 2 + rr) * 5 + c - 2 + cc + off) % 16);
      return w;
   endfunction

   task automatic beat(input bit v, input bit s);
      int c, r;
      bit ee, ef;
      logic [3:0] p;
      c = s ? 0 : mc;
      r = s ? 0 : mr;
      p = 4'((r * 5 + c) % 16);
      @(negedge clk);
      pix_valid = v;
      sof       = s;
      pix_in    = v ? {p + 4'd8, p} : 8'hFF;
      @(posedge clk);
      #1;
      ee = v && r >= 2 && c >= 2;
      ef = v && r == 3 && c == 4;
      if (ee) begin
         last_win = {wexp(r, c, 8), wexp(r, c, 0)};
         nwin++;
      end
      check("en_out", en_out, ee);
      check("frame_done", frame_done, ef);
      check("data2conv", data2conv, last_win);
      if (v) begin
         if (c == 4) begin
            c = 0;
            r = (r == 3) ? 0 : r + 1;
         end else c++;
         mc = c;
         mr = r;
      end
      pix_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic first_win_check(input string tag);
      check({tag, "_ch0"}, data2conv[35:0], 36'hCBA765210);
      check({tag, "_ch1"}, data2conv[71:36], 36'h432FEDA98);
   endtask

   initial begin
      rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
      mc = 0; mr = 0; last_win = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data2conv", data2conv, 72'd0);
      check("rst_en_out", en_out, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      @(negedge clk) rst = 1'b0;

      nwin = 0;
      for (int i = 0; i < 20; i++) begin
         beat(1'b1, i == 0);
         if (i == 12) first_win_check("seq_first_win");
      end
      check("seq_win_count", 72'(nwin), 72'd6);

      nwin = 0;
      for (int i = 0; i < 20; i++) begin
         beat(1'b1, i == 0);
         if (i == 12) first_win_check("stall_first_win");
         beat(1'b0, 1'b0);
      end
      check("stall_win_count", 72'(nwin), 72'd6);

      nwin = 0;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 20; i++) begin
            beat(1'b1, i == 0);
            if (i == 12) first_win_check("b2b_first_win");
         end
      check("b2b_win_count", 72'(nwin), 72'd12);

`ifdef CE_WIN_SOF_CHECK_EN
      check("sof_err_clean", sof_err, 1'b0);
`endif

      for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_data2conv", data2conv, 72'd0);
      check("midrst_en_out", en_out, 1'b0);
      check("midrst_frame_done", frame_done, 1'b0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      mc = 0; mr = 0; last_win = '0;
      nwin = 0;
      for (int i = 0; i < 20; i++) begin
         beat(1'b1, i == 0);
         if (i == 12) first_win_check("rst_restart_win");
      end
      check("rst_restart_count", 72'(nwin), 72'd6);

`ifdef CE_WIN_SOF_CHECK_EN
      check("sof_err_pre", sof_err, 1'b0);
      for (int i = 0; i < 7; i++) beat(1'b1, i == 0);
      nwin = 0;
      beat(1'b1, 1'b1);
      check("sof_err_set", sof_err, 1'b1);
      for (int i = 1; i < 20; i++) begin
         beat(1'b1, 1'b0);
         if (i == 12) first_win_check("resync_first_win");
      end
      check("resync_win_count", 72'(nwin), 72'd6);
      check("sof_err_sticky", sof_err, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
